// File: rtl/uart_send.sv
// 8N1 UART transmitter with a one-entry holding register in front of the shifter.
// A one-cycle tx_done pulse marks the end of every stop bit.
module uart_send #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_we,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       txd,
  output logic       tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          txd_q, txd_d;
  logic          tx_done_q, tx_done_d;
  logic          baud_end;
  logic          load;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_done_d   = 1'b0;
    load        = 1'b0;
    baud_end    = (baud_q == BAUD_LAST);

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          tx_done_d = 1'b1;
          // A queued byte starts its frame on the very edge the stop bit ends.
          if (hold_full_q) begin
            state_d = START;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = 3'd0;
    end

    // Transfer requires hold_full_q=1, so an accepted write never collides with it.
    if (tx_we && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (state_d == IDLE || state_d != state_q || baud_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + 1'b1;
    end

    // txd is registered, so it is derived from the state being entered.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      baud_q      <= '0;
      txd_q       <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_q      <= baud_d;
      txd_q       <= txd_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != IDLE);
  assign txd      = txd_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: fixed frame tables, hand-built corner sequences and random
// traffic, all checked against a frame-timing reference model.
module tb_uart_send;

  localparam int N = 4;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       tx_we   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, txd, tx_done;

  always #5 clk = ~clk;

  uart_send #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_we   (tx_we),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .txd     (txd),
    .tx_done (tx_done)
  );

  typedef struct {
    int   off;
    logic txd;
    logic busy;
    logic ready;
    logic done;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     = 0;

  // Reference model: a frame is described only by its start edge and its byte.
  bit         m_busy      = 1'b0;
  bit         m_hold_full = 1'b0;
  bit         m_done      = 1'b0;
  logic [7:0] m_cur       = 8'h00;
  logic [7:0] m_hold      = 8'h00;
  int         m_start     = 0;

  // Register-file stub: $k1[0] latches on the uart input.
  bit k1_0 = 1'b0;

  logic txd_log[256];
  logic busy_log[256];
  logic ready_log[256];
  logic done_log[256];
  logic k1_log[256];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit we, input logic [7:0] data);
    bit ready_pre;
    ready_pre = !m_hold_full;
    m_done    = 1'b0;
    if (rst) begin
      m_busy      = 1'b0;
      m_hold_full = 1'b0;
      m_hold      = 8'h00;
      m_cur       = 8'h00;
    end else begin
      if (m_busy && (cyc - m_start == 10 * N)) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      if (!m_busy && m_hold_full) begin
        m_busy      = 1'b1;
        m_start     = cyc;
        m_cur       = m_hold;
        m_hold_full = 1'b0;
      end
      if (we && ready_pre) begin
        m_hold      = data;
        m_hold_full = 1'b1;
      end
    end
  endtask

  function automatic logic m_txd();
    int idx;
    if (!m_busy) return 1'b1;
    idx = (cyc - m_start) / N;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  // One clock: drive at negedge, edge at posedge, compare at the next negedge.
  task automatic step(input bit rst, input bit we, input logic [7:0] data);
    logic done_prev;
    int   o;
    reset     = rst;
    tx_we     = we;
    tx_data   = data;
    done_prev = tx_done;
    @(posedge clk);
    cyc++;
    model_edge(rst, we, data);
    if (done_prev === 1'b1) k1_0 = 1'b1;
    @(negedge clk);
    check("txd", txd, m_txd());
    check("tx_busy", tx_busy, m_busy);
    check("tx_ready", tx_ready, !m_hold_full);
    check("tx_done", tx_done, m_done);
    o = cyc - e0;
    if (o >= 0 && o < 256) begin
      txd_log[o]   = txd;
      busy_log[o]  = tx_busy;
      ready_log[o] = tx_ready;
      done_log[o]  = tx_done;
      k1_log[o]    = k1_0;
    end
  endtask

  initial begin
    vec_t        tbl[14];
    logic [19:0] exp_bb;
    logic [9:0]  exp_ov;
    int          done_cnt;

    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("reset_txd", txd, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_done", tx_done, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

    // Single byte 0xA5: start, LSB-first data, stop, then the done pulse.
    tbl = '{
      '{0,  1'b1, 1'b0, 1'b0, 1'b0},
      '{1,  1'b0, 1'b1, 1'b1, 1'b0},
      '{5,  1'b1, 1'b1, 1'b1, 1'b0},
      '{9,  1'b0, 1'b1, 1'b1, 1'b0},
      '{13, 1'b1, 1'b1, 1'b1, 1'b0},
      '{17, 1'b0, 1'b1, 1'b1, 1'b0},
      '{21, 1'b0, 1'b1, 1'b1, 1'b0},
      '{25, 1'b1, 1'b1, 1'b1, 1'b0},
      '{29, 1'b0, 1'b1, 1'b1, 1'b0},
      '{33, 1'b1, 1'b1, 1'b1, 1'b0},
      '{37, 1'b1, 1'b1, 1'b1, 1'b0},
      '{40, 1'b1, 1'b1, 1'b1, 1'b0},
      '{41, 1'b1, 1'b0, 1'b1, 1'b1},
      '{42, 1'b1, 1'b0, 1'b1, 1'b0}
    };
    e0 = cyc + 1;
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 44; i++) step(1'b0, 1'b0, 8'h00);
    foreach (tbl[t]) begin
      check($sformatf("a5_txd@%0d", tbl[t].off), txd_log[tbl[t].off], tbl[t].txd);
      check($sformatf("a5_busy@%0d", tbl[t].off), busy_log[tbl[t].off], tbl[t].busy);
      check($sformatf("a5_ready@%0d", tbl[t].off), ready_log[tbl[t].off], tbl[t].ready);
      check($sformatf("a5_done@%0d", tbl[t].off), done_log[tbl[t].off], tbl[t].done);
    end

    // Back-to-back 0x3C then 0xFF queued at E2: no idle gap, two done pulses.
    e0 = cyc + 1;
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 84; i++) step(1'b0, 1'b0, 8'h00);
    exp_bb = 20'b1111111110_1001111000;
    for (int j = 0; j < 20; j++) check($sformatf("bb_bit%0d", j), txd_log[1 + 4*j], exp_bb[j]);
    check("bb_done40", done_log[40], 1'b0);
    check("bb_done41", done_log[41], 1'b1);
    check("bb_done42", done_log[42], 1'b0);
    check("bb_busy41", busy_log[41], 1'b1);
    check("bb_done81", done_log[81], 1'b1);
    check("bb_done82", done_log[82], 1'b0);
    check("bb_busy81", busy_log[81], 1'b0);

    // Overflow: 0x11 queued, 0x22 written while full is dropped.
    e0 = cyc + 1;
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 82; i++) step(1'b0, 1'b0, 8'h00);
    check("ov_ready2", ready_log[2], 1'b0);
    check("ov_ready3", ready_log[3], 1'b0);
    exp_ov = 10'b1000100010;
    for (int j = 0; j < 10; j++) check($sformatf("ov_bit%0d", j), txd_log[41 + 4*j], exp_ov[j]);
    check("ov_done81", done_log[81], 1'b1);

    // Reset for 3 cycles during DATA with a byte queued.
    e0 = cyc + 1;
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00);
    check("rst_mid_txd", txd_log[12], 1'b1);
    check("rst_mid_busy", busy_log[12], 1'b0);
    check("rst_mid_ready", ready_log[12], 1'b1);
    done_cnt = 0;
    for (int o = 0; o <= 72; o++) if (done_log[o] === 1'b1) done_cnt++;
    check("rst_mid_no_done", done_cnt == 0, 1'b1);

    // Register-file hookup: $k1[0] sets only after the done pulse.
    k1_0 = 1'b0;
    e0 = cyc + 1;
    step(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 44; i++) step(1'b0, 1'b0, 8'h00);
    check("k1_before20", k1_log[20], 1'b0);
    check("k1_before41", k1_log[41], 1'b0);
    check("k1_pulse41", done_log[41], 1'b1);
    check("k1_after42", k1_log[42], 1'b1);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
